// File: rtl/seq_div_base.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are caught at load and reported one cycle later.
module seq_div_base #(
    parameter int unsigned N = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [2*N-1:0] D,
    input  logic [N-1:0]   B,
    output logic [N-1:0]   Q,
    output logic [N-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  rem;
    logic [N-1:0]  qsr;
    logic [N-1:0]  bq;
    logic [CW-1:0] cnt;
    logic          err_zero;
    logic          err_ovf;

    logic [N:0]    shifted;
    logic [N-1:0]  diff;
    logic          fits;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  qsr_next;

    // rem < B always holds, so the partial remainder only needs N bits at rest;
    // the extra bit exists only in the shifted value, and the subtraction result
    // is below B whenever it is kept, so it is taken modulo 2^N.
    always_comb begin
        shifted  = {rem, qsr[N-1]};
        fits     = (shifted >= {1'b0, bq});
        diff     = shifted[N-1:0] - bq;
        rem_next = fits ? diff : shifted[N-1:0];
        qsr_next = {qsr[N-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            qsr         <= '0;
            bq          <= '0;
            cnt         <= '0;
            err_zero    <= 1'b0;
            err_ovf     <= 1'b0;
            Q           <= '0;
            R           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (load) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            Q           <= '0;
            R           <= '0;
            bq          <= B;
            cnt         <= '0;
            rem         <= D[2*N-1:N];
            qsr         <= D[N-1:0];
            err_zero    <= (B == '0);
            err_ovf     <= (B != '0) && (D[2*N-1:N] >= B);
            if ((B == '0) || (D[2*N-1:N] >= B)) begin
                state <= DONE;
                busy  <= 1'b0;
            end else begin
                state <= RUN;
                busy  <= 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    rem <= rem_next;
                    qsr <= qsr_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Q     <= qsr_next;
                        R     <= rem_next;
                    end
                end
                DONE: begin
                    // Error loads enter DONE with done still low; publish them here.
                    if (!done) begin
                        done        <= 1'b1;
                        Q           <= '1;
                        R           <= '0;
                        div_by_zero <= err_zero;
                        overflow    <= err_ovf;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
